// File: rtl/l1_request_responder_pkg.sv
// Shared request payload type for the L1 request responder.
// to_l1_arbiter_packet: word address, write data, read/not-write,
// per-byte enables (be[i] covers data[8i+7:8i]), burst size-1 and the
// conditional flag (LR when reading, SC when writing).
package l1_request_responder_pkg;

   typedef struct packed {
      logic [31:2] addr;
      logic [31:0] data;
      logic        rnw;
      logic [0:3]  be;
      logic [2:0]  size;
      logic        con;
   } to_l1_arbiter_packet;

endpackage

// File: rtl/l1_request_responder.sv
// L1 request responder: single-port word RAM serving burst reads,
// byte-enabled writes and a load-reserved / store-conditional pair.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   request_valid   request present on request
//   request         to_l1_arbiter_packet payload
//   request_ready   responder can accept (IDLE only)
//   rd_data_valid   rd_data carries a read beat this cycle
//   rd_data         read data word
//   rd_data_last    final beat of the current burst
//   sc_done         one-cycle pulse after a store-conditional is accepted
//   sc_success      store-conditional result, qualified by sc_done
module l1_request_responder
   import l1_request_responder_pkg::*;
#(
   parameter int unsigned MEM_DEPTH_WORDS = 4096
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic                request_valid,
   input  to_l1_arbiter_packet request,
   output logic                request_ready,
   output logic                rd_data_valid,
   output logic [31:0]         rd_data,
   output logic                rd_data_last,
   output logic                sc_done,
   output logic                sc_success
);

   localparam int unsigned AW = $clog2(MEM_DEPTH_WORDS);

   typedef enum logic {
      IDLE       = 1'b0,
      READ_BURST = 1'b1
   } state_t;

   // Storage and registered state
   logic [31:0]   r_mem [MEM_DEPTH_WORDS];
   state_t        r_state;
   logic [2:0]    r_remain;
   logic [AW-1:0] r_next_idx;
   logic          r_request_ready;
   logic          r_rd_valid;
   logic          r_rd_last;
   logic [31:0]   r_rd_data;
   logic          r_sc_done;
   logic          r_sc_succ;
   logic          r_res_valid;
   logic [AW-1:0] r_res_idx;

   // Next-state / combinational signals
   state_t        w_state_nxt;
   logic [2:0]    w_remain_nxt;
   logic [AW-1:0] w_next_idx_nxt;
   logic          w_ready_nxt;
   logic          w_valid_nxt;
   logic          w_last_nxt;
   logic          w_sc_done_nxt;
   logic          w_sc_succ_nxt;
   logic          w_res_valid_nxt;
   logic [AW-1:0] w_res_idx_nxt;
   logic          w_wr_en;
   logic [AW-1:0] w_rd_idx;
   logic [AW-1:0] w_req_idx;
   logic          w_accept;
   logic          w_sc_ok;
   logic          w_unused;

   // Only the index bits of the word address select a RAM word
   assign w_req_idx = request.addr[AW+1:2];
   assign w_unused  = ^request.addr[31:AW+2];
   assign w_accept  = request_valid & r_request_ready;
   assign w_sc_ok   = r_res_valid & (w_req_idx == r_res_idx);

   // State register and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state         <= IDLE;
         r_remain        <= 3'd0;
         r_next_idx      <= '0;
         r_request_ready <= 1'b1;
         r_rd_valid      <= 1'b0;
         r_rd_last       <= 1'b0;
         r_sc_done       <= 1'b0;
         r_sc_succ       <= 1'b0;
         r_res_valid     <= 1'b0;
         r_res_idx       <= '0;
      end else begin
         r_state         <= w_state_nxt;
         r_remain        <= w_remain_nxt;
         r_next_idx      <= w_next_idx_nxt;
         r_request_ready <= w_ready_nxt;
         r_rd_valid      <= w_valid_nxt;
         r_rd_last       <= w_last_nxt;
         r_sc_done       <= w_sc_done_nxt;
         r_sc_succ       <= w_sc_succ_nxt;
         r_res_valid     <= w_res_valid_nxt;
         r_res_idx       <= w_res_idx_nxt;
      end
   end

   // Next-state and output decode
   always_comb begin
      w_state_nxt     = r_state;
      w_remain_nxt    = r_remain;
      w_next_idx_nxt  = r_next_idx;
      w_valid_nxt     = 1'b0;
      w_last_nxt      = 1'b0;
      w_sc_done_nxt   = 1'b0;
      w_sc_succ_nxt   = 1'b0;
      w_res_valid_nxt = r_res_valid;
      w_res_idx_nxt   = r_res_idx;
      w_wr_en         = 1'b0;
      w_rd_idx        = r_next_idx;

      case (r_state)
         IDLE: begin
            // First beat is fetched on the acceptance edge itself
            w_rd_idx = w_req_idx;
            if (w_accept) begin
               if (request.rnw) begin
                  w_state_nxt    = READ_BURST;
                  w_remain_nxt   = request.size;
                  w_next_idx_nxt = w_req_idx + AW'(1);
                  w_valid_nxt    = 1'b1;
                  w_last_nxt     = (request.size == 3'd0);
                  if (request.con) begin
                     w_res_valid_nxt = 1'b1;
                     w_res_idx_nxt   = w_req_idx;
                  end
               end else if (request.con) begin
                  w_sc_done_nxt   = 1'b1;
                  w_sc_succ_nxt   = w_sc_ok;
                  w_wr_en         = w_sc_ok;
                  w_res_valid_nxt = 1'b0;
               end else begin
                  w_wr_en = 1'b1;
                  if (w_req_idx == r_res_idx) begin
                     w_res_valid_nxt = 1'b0;
                  end
               end
            end
         end
         READ_BURST: begin
            // r_remain counts beats still to come after the one on the bus
            if (r_remain == 3'd0) begin
               w_state_nxt = IDLE;
            end else begin
               w_remain_nxt   = r_remain - 3'd1;
               w_next_idx_nxt = r_next_idx + AW'(1);
               w_valid_nxt    = 1'b1;
               w_last_nxt     = (r_remain == 3'd1);
            end
         end
         default: w_state_nxt = IDLE;
      endcase

      w_ready_nxt = (w_state_nxt == IDLE);
   end

   // RAM: byte-enabled write, registered read; never reset
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (request.be[i]) begin
               r_mem[w_req_idx][8*i +: 8] <= request.data[8*i +: 8];
            end
         end
      end
      r_rd_data <= r_mem[w_rd_idx];
   end

   assign request_ready = r_request_ready;
   assign rd_data_valid = r_rd_valid;
   assign rd_data       = r_rd_data;
   assign rd_data_last  = r_rd_last;
   assign sc_done       = r_sc_done;
   assign sc_success    = r_sc_succ;

endmodule

// File: tb/tb_l1_request_responder.sv
// Self-checking bench for l1_request_responder: directed vector table,
// multi-cycle corner sequences and random traffic against a word-array model.
module tb_l1_request_responder;
   import l1_request_responder_pkg::*;

   localparam int unsigned DEPTH = 4096;
   localparam int OP_WR = 0;
   localparam int OP_RD = 1;
   localparam int OP_LR = 2;
   localparam int OP_SC = 3;

   logic                clk = 1'b0;
   logic                rst;
   logic                request_valid;
   to_l1_arbiter_packet request;
   logic                request_ready;
   logic                rd_data_valid;
   logic [31:0]         rd_data;
   logic                rd_data_last;
   logic                sc_done;
   logic                sc_success;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   bit [31:0]   m_mem [DEPTH];
   bit          m_res_valid = 1'b0;
   int unsigned m_res_idx   = 0;

   always #5 clk = ~clk;

   l1_request_responder #(.MEM_DEPTH_WORDS(DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .request_valid (request_valid),
      .request       (request),
      .request_ready (request_ready),
      .rd_data_valid (rd_data_valid),
      .rd_data       (rd_data),
      .rd_data_last  (rd_data_last),
      .sc_done       (sc_done),
      .sc_success    (sc_success)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_write(input int unsigned idx, input logic [31:0] data, input logic [0:3] be);
      for (int i = 0; i < 4; i++)
         if (be[i]) m_mem[idx][8*i +: 8] = data[8*i +: 8];
   endtask

   // Drive one request for exactly one edge; upper address bits are random
   task automatic present(input int unsigned idx, input logic [31:0] data, input logic [0:3] be,
                          input logic [2:0] size, input logic rnw, input logic con);
      logic [29:0] a;
      a = 30'($urandom);
      a[11:0] = 12'(idx);
      request.addr  = a;
      request.data  = data;
      request.be    = be;
      request.size  = size;
      request.rnw   = rnw;
      request.con   = con;
      request_valid = 1'b1;
      chk("ready_at_req", request_ready, 1'b1);
      @(posedge clk);
      #1;
      request_valid = 1'b0;
   endtask

   task automatic do_write(input int unsigned idx, input logic [31:0] data, input logic [0:3] be);
      present(idx, data, be, 3'($urandom), 1'b0, 1'b0);
      model_write(idx, data, be);
      if (m_res_valid && idx == m_res_idx) m_res_valid = 1'b0;
      chk("wr_no_sc_done", sc_done, 1'b0);
   endtask

   task automatic do_sc(input int unsigned idx, input logic [31:0] data, input logic [0:3] be,
                        output logic succ);
      bit exp;
      exp = m_res_valid && (idx == m_res_idx);
      present(idx, data, be, 3'($urandom), 1'b0, 1'b1);
      chk("sc_done", sc_done, 1'b1);
      chk("sc_success", sc_success, exp);
      chk("sc_no_rd_valid", rd_data_valid, 1'b0);
      if (exp) model_write(idx, data, be);
      m_res_valid = 1'b0;
      succ = sc_success;
   endtask

   task automatic do_read(input int unsigned idx, input logic [2:0] size, input logic con,
                          output logic [31:0] first);
      present(idx, 32'($urandom), 4'($urandom), size, 1'b1, con);
      if (con) begin
         m_res_valid = 1'b1;
         m_res_idx   = idx;
      end
      first = rd_data;
      for (int k = 0; k <= int'(size); k++) begin
         chk("rd_valid", rd_data_valid, 1'b1);
         chk("rd_data", rd_data, m_mem[(idx + k) % DEPTH]);
         chk("rd_last", rd_data_last, (k == int'(size)));
         chk("rd_ready_low", request_ready, 1'b0);
         chk("rd_no_sc_done", sc_done, 1'b0);
         @(posedge clk);
         #1;
      end
      chk("rd_end_valid", rd_data_valid, 1'b0);
      chk("rd_end_ready", request_ready, 1'b1);
   endtask

   typedef struct {
      int          op;
      int unsigned idx;
      logic [31:0] data;
      logic [0:3]  be;
      logic [2:0]  size;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[23];

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] rdv;
      logic        scv;

      vecs[0]  = '{OP_WR,  5, 32'hA1B2C3D4, 4'b1111, 3'd0, 32'h0};
      vecs[1]  = '{OP_RD,  5, 32'h0,        4'b0000, 3'd0, 32'hA1B2C3D4};
      vecs[2]  = '{OP_WR,  9, 32'h11223344, 4'b1111, 3'd0, 32'h0};
      vecs[3]  = '{OP_LR,  9, 32'h0,        4'b0000, 3'd0, 32'h11223344};
      vecs[4]  = '{OP_SC,  9, 32'h00000055, 4'b1000, 3'd0, 32'h1};
      vecs[5]  = '{OP_RD,  9, 32'h0,        4'b0000, 3'd0, 32'h11223355};
      vecs[6]  = '{OP_SC,  9, 32'h000000AA, 4'b1111, 3'd0, 32'h0};
      vecs[7]  = '{OP_RD,  9, 32'h0,        4'b0000, 3'd0, 32'h11223355};
      vecs[8]  = '{OP_LR,  9, 32'h0,        4'b0000, 3'd0, 32'h11223355};
      vecs[9]  = '{OP_WR,  9, 32'h00000066, 4'b1000, 3'd0, 32'h0};
      vecs[10] = '{OP_SC,  9, 32'h77777777, 4'b1111, 3'd0, 32'h0};
      vecs[11] = '{OP_RD,  9, 32'h0,        4'b0000, 3'd0, 32'h11223366};
      vecs[12] = '{OP_WR, 10, 32'hCAFEF00D, 4'b1111, 3'd0, 32'h0};
      vecs[13] = '{OP_LR,  9, 32'h0,        4'b0000, 3'd0, 32'h11223366};
      vecs[14] = '{OP_SC, 10, 32'hFFFFFFFF, 4'b1111, 3'd0, 32'h0};
      vecs[15] = '{OP_RD, 10, 32'h0,        4'b0000, 3'd0, 32'hCAFEF00D};
      vecs[16] = '{OP_WR,  5, 32'h0000EE00, 4'b0100, 3'd0, 32'h0};
      vecs[17] = '{OP_RD,  5, 32'h0,        4'b0000, 3'd0, 32'hA1B2EED4};
      vecs[18] = '{OP_WR, 20, 32'hDEADBEEF, 4'b1111, 3'd0, 32'h0};
      vecs[19] = '{OP_LR, 20, 32'h0,        4'b0000, 3'd0, 32'hDEADBEEF};
      vecs[20] = '{OP_SC, 20, 32'h00000012, 4'b1000, 3'd0, 32'h1};
      vecs[21] = '{OP_SC, 20, 32'h00000034, 4'b1000, 3'd0, 32'h0};
      vecs[22] = '{OP_RD, 20, 32'h0,        4'b0000, 3'd0, 32'hDEADBE12};

      // Reset state
      rst           = 1'b1;
      request_valid = 1'b0;
      request       = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", request_ready, 1'b1);
      chk("rst_rd_valid", rd_data_valid, 1'b0);
      chk("rst_rd_last", rd_data_last, 1'b0);
      chk("rst_sc_done", sc_done, 1'b0);
      chk("rst_sc_success", sc_success, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Give every RAM word a known value
      for (int unsigned i = 0; i < DEPTH; i++) do_write(i, $urandom, 4'b1111);

      // Directed vector table
      for (int v = 0; v < 23; v++) begin
         case (vecs[v].op)
            OP_WR: do_write(vecs[v].idx, vecs[v].data, vecs[v].be);
            OP_RD, OP_LR: begin
               do_read(vecs[v].idx, vecs[v].size, (vecs[v].op == OP_LR), rdv);
               chk($sformatf("vec%0d_rd", v), rdv, vecs[v].exp);
            end
            default: begin
               do_sc(vecs[v].idx, vecs[v].data, vecs[v].be, scv);
               chk($sformatf("vec%0d_sc", v), scv, vecs[v].exp);
            end
         endcase
      end

      // Eight-beat burst over preloaded words
      for (int unsigned i = 0; i < 8; i++) do_write(i, 32'h100 + i, 4'b1111);
      do_read(0, 3'd7, 1'b0, rdv);
      chk("burst8_first", rdv, 32'h100);

      // Wrap-around burst at the top of the RAM
      do_write(4094, 32'hAAAA0001, 4'b1111);
      do_write(4095, 32'hAAAA0002, 4'b1111);
      do_write(0,    32'hAAAA0003, 4'b1111);
      do_write(1,    32'hAAAA0004, 4'b1111);
      do_read(4094, 3'd3, 1'b0, rdv);
      chk("wrap_first", rdv, 32'hAAAA0001);

      // Reset during beat 3 of an LR burst
      present(30, 32'h0, 4'b0000, 3'd7, 1'b1, 1'b1);
      for (int k = 0; k < 3; k++) begin
         chk("abort_pre_valid", rd_data_valid, 1'b1);
         chk("abort_pre_data", rd_data, m_mem[30 + k]);
         @(posedge clk);
         #1;
      end
      chk("abort_beat3_valid", rd_data_valid, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk("abort_async_valid", rd_data_valid, 1'b0);
      chk("abort_async_last", rd_data_last, 1'b0);
      chk("abort_async_ready", request_ready, 1'b1);
      m_res_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         chk("abort_no_beats", rd_data_valid, 1'b0);
         chk("abort_ready", request_ready, 1'b1);
      end
      do_sc(30, 32'h12345678, 4'b1111, scv);
      chk("abort_res_cleared", scv, 1'b0);
      do_read(30, 3'd2, 1'b0, rdv);

      // Random traffic against the model
      for (int n = 0; n < 400; n++) begin
         int unsigned r;
         int unsigned idx;
         r   = $urandom_range(0, 9);
         idx = ($urandom_range(0, 3) == 0) ? (DEPTH - 1 - $urandom_range(0, 3))
                                           : $urandom_range(0, 15);
         if (r == 0) begin
            @(posedge clk);
            #1;
            chk("idle_rd_valid", rd_data_valid, 1'b0);
            chk("idle_sc_done", sc_done, 1'b0);
            chk("idle_ready", request_ready, 1'b1);
         end else if (r <= 3) begin
            do_write(idx, $urandom, 4'($urandom));
         end else if (r <= 5) begin
            do_read(idx, 3'($urandom), 1'b0, rdv);
         end else if (r == 6) begin
            do_read(idx, 3'($urandom), 1'b1, rdv);
         end else begin
            do_sc(idx, $urandom, 4'($urandom), scv);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/l1_request_responder.md
L1_REQUEST_RESPONDER -- requirements
Module: l1_request_responder

Interface
REQ-001 Parameter MEM_DEPTH_WORDS, default 4096, power of two, word depth of internal RAM.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 request_valid  input  1  request present on request.
REQ-005 request  input  to_l1_arbiter_packet  addr[31:2], data, rnw, be[0:3], size, con.
REQ-006 request_ready  output  1  responder can accept; transfer occurs when request_valid and request_ready are both high at a rising edge.
REQ-007 rd_data_valid  output  1  rd_data holds a read word this cycle.
REQ-008 rd_data  output  32  read data word.
REQ-009 rd_data_last  output  1  final word of the current read burst.
REQ-010 sc_done  output  1  one-cycle pulse: a conditional store has resolved.
REQ-011 sc_success  output  1  conditional-store result; valid only while sc_done is high.

Function
REQ-012 The RAM index is addr[$clog2(MEM_DEPTH_WORDS)+1:2]; upper address bits are ignored.
REQ-013 The FSM has states IDLE and READ_BURST; request_ready is high in IDLE only.
REQ-014 Read (rnw=1): on acceptance, latch base index and count = size+1 (1..8 words), then go to READ_BURST.
REQ-015 READ_BURST: beat k (k=0..size) presents RAM[(base+k) mod MEM_DEPTH_WORDS] on rd_data with rd_data_valid high, starting the cycle after acceptance, one beat per cycle, no gaps, no backpressure.
REQ-016 rd_data_last is high on beat k=size only; the FSM returns to IDLE on the edge ending that beat, so request_ready is high the cycle after the last beat.
REQ-017 Read latency: first word 1 cycle after acceptance; minimum request-to-request spacing for reads is size+2 cycles.
REQ-018 Load-reserved (rnw=1, con=1): behaves as a read and additionally sets reservation_valid=1 and reservation_index=base index at acceptance.
REQ-019 Write (rnw=0, con=0): at the acceptance edge, for each i in 0..3 with be[i]=1, write data[8i+7:8i] into byte i of RAM[index]; size is ignored; FSM stays in IDLE, so writes may be accepted every cycle.
REQ-020 A plain write whose index equals reservation_index clears reservation_valid.
REQ-021 Store-conditional (rnw=0, con=1): success = reservation_valid and index == reservation_index; on success the byte-enabled write is performed as in REQ-019, on failure no RAM change; reservation_valid is cleared in either case.
REQ-022 sc_done pulses high the cycle after SC acceptance with sc_success = the result; sc_done and sc_success are low in every other cycle.
REQ-023 Back-to-back SCs each produce their own sc_done pulse on consecutive cycles.
REQ-024 A read accepted the cycle after a write to the same index returns the newly written data (write-before-read ordering).
REQ-025 rd_data is don't-care when rd_data_valid is low; rd_data_valid and sc_done are never both high.

Reset
REQ-026 While rst is high: FSM=IDLE, request_ready=1, rd_data_valid=0, rd_data_last=0, sc_done=0, sc_success=0, reservation_valid=0, burst counters=0.
REQ-027 rst asserted mid-burst aborts the burst immediately (asynchronously); no further beats are emitted after reset releases.
REQ-028 RAM contents are not affected by reset.

Verification
REQ-029 Write addr word 5, data 0xA1B2C3D4, be all ones; then read word 5 with size=0 -> one beat 0xA1B2C3D4, rd_data_last=1, 1 cycle after acceptance.
REQ-030 Preload words 0..7 with 0x100+i; read base 0, size=7 -> 8 consecutive beats 0x100..0x107, last on the 8th beat, request_ready low for 8 cycles and then high.
REQ-031 With MEM_DEPTH_WORDS=4096, read base 4094, size=3 -> words 4094, 4095, 0, 1 in that order (wrap-around).
REQ-032 LR word 9; SC word 9, data 0x55, be[0] only -> sc_done=1, sc_success=1, byte 0 updated; a second SC to word 9 -> sc_success=0, RAM unchanged.
REQ-033 LR word 9; plain write to word 9; SC word 9 -> sc_success=0. LR word 9 then SC word 10 -> sc_success=0.
REQ-034 Assert rst during beat 3 of a size=7 burst -> rd_data_valid=0 immediately, request_ready=1 after release, no residual beats, reservation cleared.
